// File: rtl/registro_bcd2bin_param.sv
// Iterative BCD-to-binary converter (shift right, subtract 3 per nibble >= 8).
// One iteration per falling edge of reloj; result held until next start/abort.
module registro_bcd2bin_param #(
  parameter int DIGITOS         = 3,
  parameter int ANCHO_BIN       = 10,
  parameter bit INVERTIR_SALIDA = 1'b1
) (
  input  logic                   reloj,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic                   cancelar,
  input  logic [4*DIGITOS-1:0]   entrada,
  input  logic                   habilitar_salida,
  output logic [ANCHO_BIN-1:0]   salida,
  output logic                   ocupado,
  output logic                   listo,
  output logic                   error_bcd
);

  localparam int ANCHO_BCD = 4 * DIGITOS;
  localparam int ANCHO_CNT = $clog2(ANCHO_BIN + 1);

  typedef enum logic [1:0] {
    REPOSO,
    CONVIRTIENDO,
    LISTO
  } estado_t;

  estado_t                      estado, estado_sig;
  logic [ANCHO_BCD-1:0]         bcd_q, bcd_d;
  logic [ANCHO_BIN-1:0]         bin_q, bin_d;
  logic [ANCHO_BIN-1:0]         resultado_q;
  logic [ANCHO_CNT-1:0]         cuenta_q;
  logic                         error_q;
  logic [ANCHO_BCD+ANCHO_BIN-1:0] desplazado;
  logic                         digito_invalido;
  logic                         ultima;
  logic                         arranque;

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    digito_invalido = 1'b0;
    for (int i = 0; i < DIGITOS; i++) begin
      if (entrada[4*i +: 4] > 4'd9) digito_invalido = 1'b1;
    end
  end

  assign ultima   = (cuenta_q == ANCHO_CNT'(ANCHO_BIN - 1));
  assign arranque = (estado != CONVIRTIENDO) && inicio;

  // One conversion step: shift the joint register right, then correct each BCD nibble.
  always_comb begin
    desplazado = {bcd_q, bin_q} >> 1;
    bcd_d      = desplazado[ANCHO_BCD+ANCHO_BIN-1 -: ANCHO_BCD];
    bin_d      = desplazado[ANCHO_BIN-1:0];
    for (int i = 0; i < DIGITOS; i++) begin
      if (bcd_d[4*i +: 4] >= 4'd8) bcd_d[4*i +: 4] = bcd_d[4*i +: 4] - 4'd3;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(negedge reloj or posedge reset) begin
    if (reset) estado <= REPOSO;
    else       estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    if (cancelar) begin
      estado_sig = REPOSO;
    end else begin
      unique case (estado)
        REPOSO, LISTO: begin
          if (inicio) estado_sig = digito_invalido ? LISTO : CONVIRTIENDO;
        end
        CONVIRTIENDO: begin
          if (ultima) estado_sig = LISTO;
        end
        default: estado_sig = REPOSO;
      endcase
    end
  end

  // Datapath: working register, iteration counter, result and error flag.
  always_ff @(negedge reloj or posedge reset) begin
    if (reset) begin
      bcd_q       <= '0;
      bin_q       <= '0;
      cuenta_q    <= '0;
      resultado_q <= '0;
      error_q     <= 1'b0;
    end else if (cancelar) begin
      bcd_q       <= '0;
      bin_q       <= '0;
      cuenta_q    <= '0;
      resultado_q <= '0;
      error_q     <= 1'b0;
    end else if (arranque) begin
      cuenta_q    <= '0;
      resultado_q <= '0;
      bin_q       <= '0;
      if (digito_invalido) begin
        bcd_q   <= '0;
        error_q <= 1'b1;
      end else begin
        bcd_q   <= entrada;
        error_q <= 1'b0;
      end
    end else if (estado == CONVIRTIENDO) begin
      bcd_q    <= bcd_d;
      bin_q    <= bin_d;
      cuenta_q <= cuenta_q + ANCHO_CNT'(1);
      if (ultima) resultado_q <= bin_d;
    end
  end

  always_comb begin
    ocupado   = (estado == CONVIRTIENDO);
    listo     = (estado == LISTO);
    error_bcd = error_q;
    if (!habilitar_salida)    salida = '0;
    else if (INVERTIR_SALIDA) salida = ~resultado_q;
    else                      salida = resultado_q;
  end

endmodule

// File: tb/tb_registro_bcd2bin_param.sv
// Self-checking bench: three converter configurations against an arithmetic BCD model.
module tb_registro_bcd2bin_param;

  logic        reloj = 1'b1;
  logic        reset;
  logic        inicio, cancelar, hab;
  logic [11:0] entrada;
  logic [9:0]  s0, s1;
  logic        oc0, li0, er0, oc1, li1, er1;

  logic        inicio2, cancelar2, hab2;
  logic [15:0] entrada2;
  logic [13:0] s2;
  logic        oc2, li2, er2;

  int tests = 0;
  int fails = 0;

  always #5 reloj = ~reloj;

  registro_bcd2bin_param u0 (
    .reloj(reloj), .reset(reset), .inicio(inicio), .cancelar(cancelar),
    .entrada(entrada), .habilitar_salida(hab), .salida(s0),
    .ocupado(oc0), .listo(li0), .error_bcd(er0)
  );

  registro_bcd2bin_param #(.INVERTIR_SALIDA(1'b0)) u1 (
    .reloj(reloj), .reset(reset), .inicio(inicio), .cancelar(cancelar),
    .entrada(entrada), .habilitar_salida(hab), .salida(s1),
    .ocupado(oc1), .listo(li1), .error_bcd(er1)
  );

  registro_bcd2bin_param #(.DIGITOS(4), .ANCHO_BIN(14), .INVERTIR_SALIDA(1'b0)) u2 (
    .reloj(reloj), .reset(reset), .inicio(inicio2), .cancelar(cancelar2),
    .entrada(entrada2), .habilitar_salida(hab2), .salida(s2),
    .ocupado(oc2), .listo(li2), .error_bcd(er2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled on the rising edge, half a period after the active falling edge.
  task automatic tick();
    @(negedge reloj);
    @(posedge reloj);
  endtask

  function automatic int bcd_valor(input logic [23:0] b, input int d);
    int v = 0;
    int p = 1;
    for (int i = 0; i < d; i++) begin
      logic [3:0] dig = b[4*i +: 4];
      v += int'(dig) * p;
      p *= 10;
    end
    return v;
  endfunction

  function automatic bit bcd_malo(input logic [23:0] b, input int d);
    for (int i = 0; i < d; i++) begin
      logic [3:0] dig = b[4*i +: 4];
      if (dig > 4'd9) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] esperado(input int v, input bit en, input bit inv, input int w);
    logic [31:0] m = (32'h1 << w) - 32'h1;
    if (!en) return 32'h0;
    if (inv) return ~v & m;
    return v & m;
  endfunction

  // Full conversion on the two 3-digit instances with latency checks.
  task automatic run3(input logic [11:0] bcd, input bit en);
    int  v   = bcd_malo({12'h0, bcd}, 3) ? 0 : bcd_valor({12'h0, bcd}, 3);
    bit  err = bcd_malo({12'h0, bcd}, 3);
    entrada = bcd; hab = en; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    if (err) begin
      check("err_listo", li0, 1'b1);
      check("err_flag", er0, 1'b1);
      check("err_ocupado", oc0, 1'b0);
    end else begin
      check("arranque_ocupado", oc0, 1'b1);
      repeat (9) tick();
      check("penultimo_ocupado", oc0, 1'b1);
      check("penultimo_listo", li0, 1'b0);
      tick();
      check("fin_listo", li0, 1'b1);
      check("fin_ocupado", oc0, 1'b0);
      check("fin_error", er0, 1'b0);
    end
    check("salida_inv", s0, esperado(v, en, 1'b1, 10));
    check("salida_dir", s1, esperado(v, en, 1'b0, 10));
    check("listo_dir", li1, 1'b1);
  endtask

  task automatic run4(input logic [15:0] bcd);
    int v   = bcd_valor({8'h0, bcd}, 4);
    bit err = bcd_malo({8'h0, bcd}, 4);
    entrada2 = bcd; hab2 = 1'b1; inicio2 = 1'b1;
    tick();
    inicio2 = 1'b0;
    if (!err) begin
      repeat (13) tick();
      check("d4_penultimo_listo", li2, 1'b0);
      tick();
    end
    check("d4_listo", li2, 1'b1);
    check("d4_error", er2, err);
    check("d4_salida", s2, esperado(err ? 0 : v, 1'b1, 1'b0, 14));
  endtask

  initial begin
    reset = 1'b1; inicio = 1'b0; cancelar = 1'b0; hab = 1'b1; entrada = '0;
    inicio2 = 1'b0; cancelar2 = 1'b0; hab2 = 1'b1; entrada2 = '0;
    #1;
    check("rst_ocupado", oc0, 1'b0);
    check("rst_listo", li0, 1'b0);
    check("rst_error", er0, 1'b0);
    check("rst_salida_dir", s1, 10'h000);
    check("rst_salida_inv", s0, 10'h3FF);
    @(posedge reloj);
    reset = 1'b0;

    // Nominal inverted result, then hold across an idle edge.
    run3(12'h255, 1'b1);
    check("ej_255_inv", s0, 10'h300);
    tick();
    check("retiene_listo", li0, 1'b1);
    check("retiene_salida", s1, 10'd255);

    // Maximum 3-digit value, then output disable.
    run3(12'h999, 1'b1);
    check("ej_999_dir", s1, 10'h3E7);
    hab = 1'b0; #1;
    check("deshab_dir", s1, 10'h000);
    check("deshab_inv", s0, 10'h000);
    hab = 1'b1;

    // Invalid digit: one-edge error result.
    run3(12'h1A3, 1'b1);
    check("ej_1a3_inv", s0, 10'h3FF);

    // Zero, then a start pulse during a running conversion is ignored.
    run3(12'h000, 1'b1);
    entrada = 12'h128; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    repeat (3) tick();
    entrada = 12'h999; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    check("ignora_inicio_ocupado", oc0, 1'b1);
    repeat (5) tick();
    check("ignora_penultimo", li0, 1'b0);
    tick();
    check("ignora_listo", li0, 1'b1);
    check("ignora_128", s1, 10'd128);

    // Asynchronous reset at iteration 5.
    entrada = 12'h777; inicio = 1'b1;
    tick();
    inicio = 1'b0;
    repeat (4) tick();
    reset = 1'b1; #1;
    check("rst_async_ocupado", oc0, 1'b0);
    check("rst_async_listo", li0, 1'b0);
    check("rst_async_salida", s1, 10'h000);
    reset = 1'b0;
    run3(12'h042, 1'b1);
    check("tras_rst_42", s1, 10'd42);

    // Cancel wins over start in LISTO.
    entrada = 12'h321; inicio = 1'b1; cancelar = 1'b1;
    tick();
    inicio = 1'b0; cancelar = 1'b0;
    check("cancela_listo", li0, 1'b0);
    check("cancela_ocupado", oc0, 1'b0);
    check("cancela_salida", s1, 10'h000);

    // Randomized 3-digit values, occasionally with an invalid digit.
    for (int n = 0; n < 16; n++) begin
      logic [11:0] b;
      for (int i = 0; i < 3; i++)
        b[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      run3(b, $urandom_range(0, 3) != 0);
    end

    // Four-digit configuration, then cancel at iteration 7.
    run4(16'h9999);
    check("d4_9999", s2, 14'd9999);
    entrada2 = 16'h9999; inicio2 = 1'b1;
    tick();
    inicio2 = 1'b0;
    repeat (6) tick();
    cancelar2 = 1'b1;
    tick();
    cancelar2 = 1'b0;
    check("d4_cancel_listo", li2, 1'b0);
    check("d4_cancel_ocupado", oc2, 1'b0);
    check("d4_cancel_salida", s2, 14'd0);
    for (int n = 0; n < 6; n++) begin
      logic [15:0] b;
      for (int i = 0; i < 4; i++)
        b[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      run4(b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
